// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA bus initiator that copies word_count 32-bit words
// from src_addr to dst_addr. It shares the memory bus with the CPU through
// a req/gnt handshake and drives the same address/data/strobe lines as the CPU.
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   start           launch request, sampled only in IDLE
//   src_addr        source byte address (word aligned), latched on start
//   dst_addr        destination byte address (word aligned), latched on start
//   word_count      number of words to copy, latched on start
//   bus_gnt         arbiter grant; the engine owns the bus only while high
//   Read_Data_i     combinational read data from the memory system
//   bus_req         bus request
//   Address_o       memory byte address
//   Write_Data_o    memory write data (always the word buffer)
//   Write_Enable_o  memory write strobe, gated by bus_gnt
//   busy            copy in progress
//   done            one-cycle pulse when a copy completes
//   error           one-cycle pulse when a start is rejected
module mem_copy_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [CNT_W-1:0]      word_count,
  input  logic                  bus_gnt,
  input  logic [DATA_WIDTH-1:0] Read_Data_i,
  output logic                  bus_req,
  output logic [31:0]           Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  Write_Enable_o,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]     dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0]      remain_q, remain_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;

  // State, pointers, counter and word buffer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      remain_q  <= '0;
      buf_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      remain_q  <= remain_d;
      buf_q     <= buf_d;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_d        = state_q;
    src_ptr_d      = src_ptr_q;
    dst_ptr_d      = dst_ptr_q;
    remain_d       = remain_q;
    buf_d          = buf_q;
    bus_req        = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    Address_o      = '0;
    Write_Enable_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            state_d = S_ERR;
          end else if (word_count == '0) begin
            state_d = S_DONE;
          end else begin
            src_ptr_d = src_addr;
            dst_ptr_d = dst_addr;
            remain_d  = word_count;
            state_d   = S_REQ;
          end
        end
      end

      S_REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) state_d = S_READ;
      end

      S_READ: begin
        bus_req   = 1'b1;
        busy      = 1'b1;
        Address_o = src_ptr_q;
        if (bus_gnt) begin
          buf_d   = Read_Data_i;
          state_d = S_WRITE;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WRITE: begin
        bus_req        = 1'b1;
        busy           = 1'b1;
        Address_o      = dst_ptr_q;
        // Strobe follows grant so a lost grant never produces a write
        Write_Enable_o = bus_gnt;
        if (bus_gnt) begin
          src_ptr_d = src_ptr_q + ADDR_W'(4);
          dst_ptr_d = dst_ptr_q + ADDR_W'(4);
          remain_d  = remain_q - CNT_W'(1);
          state_d   = (remain_q == CNT_W'(1)) ? S_DONE : S_READ;
        end else begin
          // Word is re-read after the grant returns
          state_d = S_REQ;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      S_ERR: begin
        error   = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign Write_Data_o = buf_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: memory/IO model, write scoreboard and
// directed copy scenarios.
module tb_mem_copy_engine;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_count = '0;
  logic        bus_gnt = 1'b1;
  logic [31:0] Read_Data_i;
  logic        bus_req;
  logic [31:0] Address_o;
  logic [31:0] Write_Data_o;
  logic        Write_Enable_o;
  logic        busy;
  logic        done;
  logic        error;

  mem_copy_engine #(.DATA_WIDTH(32), .CNT_W(16)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .start          (start),
    .src_addr       (src_addr),
    .dst_addr       (dst_addr),
    .word_count     (word_count),
    .bus_gnt        (bus_gnt),
    .Read_Data_i    (Read_Data_i),
    .bus_req        (bus_req),
    .Address_o      (Address_o),
    .Write_Data_o   (Write_Data_o),
    .Write_Enable_o (Write_Enable_o),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 CLK = ~CLK;

  // Memory model: 64-word RAM at 0x1001_0000, I/O ports, words at the wrap point
  bit   [31:0] ram [64];
  logic [31:0] in_port1  = 32'h0;
  logic [31:0] out_port1 = 32'h0;
  logic [31:0] hi_word   = 32'h0;
  logic [31:0] lo_word   = 32'h0;
  logic        pl_en     = 1'b0;
  logic [31:0] pl_addr   = '0;
  logic [31:0] pl_data   = '0;
  logic        wen;
  logic [31:0] wa, wd;

  always_comb begin
    Read_Data_i = 32'h0;
    if (Address_o[31:8] == 24'h10_0100) Read_Data_i = ram[Address_o[7:2]];
    else if (Address_o == 32'h003F_FFBC) Read_Data_i = in_port1;
    else if (Address_o == 32'hFFFF_FFFC) Read_Data_i = hi_word;
    else if (Address_o == 32'h0000_0000) Read_Data_i = lo_word;
  end

  always_comb begin
    wen = pl_en | Write_Enable_o;
    wa  = pl_en ? pl_addr : Address_o;
    wd  = pl_en ? pl_data : Write_Data_o;
  end

  always @(posedge CLK) begin
    if (wen) begin
      if (wa[31:8] == 24'h10_0100) ram[wa[7:2]] <= wd;
      else if (wa == 32'h003F_FFC0) out_port1 <= wd;
      else if (wa == 32'hFFFF_FFFC) hi_word <= wd;
      else if (wa == 32'h0000_0000) lo_word <= wd;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  int req_cnt = 0, done_cnt = 0, err_cnt = 0, we_cnt = 0;

  // Event counters and write scoreboard, sampled mid-cycle
  always @(negedge CLK) begin
    wr_t e;
    if (bus_req) req_cnt++;
    if (done)    done_cnt++;
    if (error)   err_cnt++;
    if (Write_Enable_o) begin
      we_cnt++;
      chk("we_needs_gnt", 32'(bus_gnt), 32'd1);
      chk("sb_write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_addr", Address_o, e.addr);
        chk("sb_data", Write_Data_o, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  // Returns positioned in cycle 1 (one cycle after start was sampled)
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    src_addr   = s;
    dst_addr   = d;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int first, output int cyc);
    cyc = first;
    while (done !== 1'b1 && cyc < first + 400) begin
      tick();
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  localparam logic [31:0] WA = 32'hA0A0_0001;
  localparam logic [31:0] WB = 32'hB0B0_0002;
  localparam logic [31:0] WC = 32'hC0C0_0003;
  localparam logic [31:0] WD = 32'hD0D0_0004;
  localparam logic [31:0] WE = 32'hE0E0_0005;

  initial begin
    int cyc;
    int snap_a, snap_b;

    // Reset state
    #1 RST = 1'b1;
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_addr", Address_o, 32'd0);
    chk("rst_wdata", Write_Data_o, 32'd0);
    chk("rst_busy_done_err_we", 32'({busy, done, error, Write_Enable_o}), 32'd0);
    tick();
    tick();
    RST = 1'b0;

    preload(32'h1001_0000, WA);
    preload(32'h1001_0004, WB);
    preload(32'h1001_0008, WC);
    preload(32'h1001_0010, WD);
    preload(32'h1001_0014, WE);
    for (int i = 0; i < 4; i++) preload(32'h1001_0020 + 32'(4 * i), 32'h5500_0000 + 32'(i));

    // 1: three-word copy with continuous grant
    bus_gnt = 1'b1;
    push(32'h1001_0040, WA);
    push(32'h1001_0044, WB);
    push(32'h1001_0048, WC);
    do_start(32'h1001_0000, 32'h1001_0040, 16'd3);
    chk("t1_req_c1", 32'({bus_req, busy, Write_Enable_o}), 32'b110);
    chk("t1_addr_c1", Address_o, 32'd0);
    wait_done(1, cyc);
    chk("t1_done_cycle", 32'(cyc), 32'd8);
    chk("t1_ram40", 32'(ram[16]), WA);
    chk("t1_ram44", 32'(ram[17]), WB);
    chk("t1_ram48", 32'(ram[18]), WC);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2: grant withheld, then lost during the first write
    bus_gnt = 1'b0;
    snap_a  = done_cnt;
    push(32'h1001_0060, WD);
    push(32'h1001_0064, WE);
    do_start(32'h1001_0010, 32'h1001_0060, 16'd2);
    tick();
    tick();
    chk("t2_wait_req", 32'({bus_req, Write_Enable_o}), 32'b10);
    chk("t2_wait_addr", Address_o, 32'd0);
    tick();
    bus_gnt = 1'b1;
    tick();
    chk("t2_read0_addr", Address_o, 32'h1001_0010);
    tick();
    chk("t2_write0_addr", Address_o, 32'h1001_0060);
    bus_gnt = 1'b0;
    #1;
    chk("t2_we_no_gnt", 32'(Write_Enable_o), 32'd0);
    tick();
    bus_gnt = 1'b1;
    tick();
    chk("t2_reread_addr", Address_o, 32'h1001_0010);
    wait_done(8, cyc);
    chk("t2_done_cycle", 32'(cyc), 32'd12);
    chk("t2_ram60", 32'(ram[24]), WD);
    chk("t2_ram64", 32'(ram[25]), WE);
    chk("t2_done_once", 32'(done_cnt - snap_a), 32'd1);

    // 3a: misaligned source rejected
    snap_a = req_cnt;
    do_start(32'h1001_0002, 32'h1001_0040, 16'd2);
    chk("t3_error", 32'({error, busy}), 32'b10);
    tick();
    chk("t3_error_one_cycle", 32'(error), 32'd0);
    tick();
    chk("t3_no_req", 32'(req_cnt - snap_a), 32'd0);

    // 3b: empty copy completes immediately
    snap_b = we_cnt;
    do_start(32'h1001_0000, 32'h1001_0070, 16'd0);
    chk("t3_empty_done_c1", 32'({done, busy}), 32'b10);
    tick();
    chk("t3_empty_done_pulse", 32'(done), 32'd0);
    tick();
    chk("t3_empty_no_we", 32'(we_cnt - snap_b), 32'd0);

    // 4: reset while writing word 1 of 4
    push(32'h1001_00A0, 32'h5500_0000);
    do_start(32'h1001_0020, 32'h1001_00A0, 16'd4);
    tick();
    tick();
    tick();
    tick();
    chk("t4_write1_addr", Address_o, 32'h1001_00A4);
    RST = 1'b1;
    #1;
    chk("t4_async_addr", Address_o, 32'd0);
    chk("t4_async_wdata", Write_Data_o, 32'd0);
    chk("t4_async_ctl", 32'({bus_req, busy, Write_Enable_o, done, error}), 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("t4_word1_unwritten", 32'(ram[41]), 32'd0);
    chk("t4_sb_drained", 32'(sb_q.size()), 32'd0);
    push(32'h1001_00C0, WA);
    push(32'h1001_00C4, WB);
    do_start(32'h1001_0000, 32'h1001_00C0, 16'd2);
    wait_done(1, cyc);
    chk("t4_restart_done_cycle", 32'(cyc), 32'd6);
    chk("t4_ramC4", 32'(ram[49]), WB);

    // 5: input port to output port
    in_port1 = 32'hDEAD_BEEF;
    push(32'h003F_FFC0, 32'hDEAD_BEEF);
    do_start(32'h003F_FFBC, 32'h003F_FFC0, 16'd1);
    wait_done(1, cyc);
    chk("t5_done_cycle", 32'(cyc), 32'd4);
    chk("t5_out_port1", out_port1, 32'hDEAD_BEEF);

    // 6a: source pointer wraps through zero
    preload(32'hFFFF_FFFC, 32'h1111_2222);
    preload(32'h0000_0000, 32'h3333_4444);
    push(32'h1001_00E0, 32'h1111_2222);
    push(32'h1001_00E4, 32'h3333_4444);
    do_start(32'hFFFF_FFFC, 32'h1001_00E0, 16'd2);
    tick();
    chk("t6_read0_addr", Address_o, 32'hFFFF_FFFC);
    tick();
    tick();
    chk("t6_wrap_addr", Address_o, 32'h0000_0000);
    wait_done(4, cyc);
    chk("t6_wrap_done_cycle", 32'(cyc), 32'd6);

    // 6b: start while busy is ignored
    snap_a = done_cnt;
    snap_b = we_cnt;
    push(32'h1001_0080, WA);
    push(32'h1001_0084, WB);
    push(32'h1001_0088, WC);
    do_start(32'h1001_0000, 32'h1001_0080, 16'd3);
    tick();
    tick();
    src_addr   = 32'h1001_0030;
    dst_addr   = 32'h1001_0090;
    word_count = 16'd1;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    wait_done(4, cyc);
    chk("t6_ign_done_cycle", 32'(cyc), 32'd8);
    tick();
    chk("t6_ign_idle", 32'({busy, bus_req}), 32'd0);
    chk("t6_ign_done_cnt", 32'(done_cnt - snap_a), 32'd1);
    chk("t6_ign_we_cnt", 32'(we_cnt - snap_b), 32'd3);
    chk("t6_ign_ram90", 32'(ram[36]), 32'd0);
    chk("t6_ign_ram88", 32'(ram[34]), WC);
    chk("end_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
